opp_packet_rx: RTL
==================

Name: opp_packet_rx

Overview:
- Receive-side parser between the network byte stream and the game logic.
- Consumes byte-wide streamed frames carrying the opponent's kart state and checks the header, length, checksum and direction range.
- On a valid frame, registers the opponent fields and pulses the valid strobe that the game module samples (receive_axiiv).
- Also tracks link liveness and counts errored frames.

Parameters:
- HEADER, 8'hA5, required first byte of every frame.
- DIR_MAX, 359, largest legal direction value (the trig ROM depth is 360).
- INIT_X, 300, reset value of r_opp_x.
- INIT_Y, 100, reset value of r_opp_y.
- INIT_DIR, 90, reset value of r_opp_dir.
- TIMEOUT_CYCLES, 6_500_000, number of cycles without a valid frame before link_up drops.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- axiiv  in  1  byte valid; held high for the whole frame; a low cycle marks end of frame.
- axiid  in  8  byte data.
- r_opp_x  out  11  opponent x.
- r_opp_y  out  11  opponent y.
- r_opp_dir  out  9  opponent direction, 0..DIR_MAX.
- r_opp_game  out  3  opponent game status.
- r_opp_rst  out  1  one-cycle pulse requesting a game reset.
- receive_axiiv  out  1  one-cycle valid strobe.
- link_up  out  1  high while frames are arriving.
- rx_err_count  out  8  errored-frame count, saturating.

Behaviour:
- Frame format is 7 bytes: HEADER, P0..P4, CHK.
- Payload is 40 bits, MSB first:
  - [39:29] x
  - [28:18] y
  - [17:9] dir
  - [8:6] game
  - [5] rst
  - [4:0] reserved, ignored.
- CHK = (P0+...+P4) mod 256. The header is excluded from the checksum.
- FSM states: IDLE, PAYLOAD, CHK, WAIT_END, DROP.
  - IDLE: axiiv=1 with axiid==HEADER goes to PAYLOAD. Any other byte goes to DROP and counts an error.
  - PAYLOAD: shift in 5 bytes and accumulate the 8-bit sum. If axiiv falls early, count an error and go to IDLE.
  - CHK: capture the byte. If axiiv falls, count an error and go to IDLE. Otherwise go to WAIT_END.
  - WAIT_END: axiiv=1 means the frame is too long; count an error and go to DROP. On axiiv=0, commit if CHK matches and dir<=DIR_MAX, otherwise count an error. Either way go to IDLE.
  - DROP: stay until axiiv=0, then go to IDLE.
- Commit: outputs are written on the edge that samples the first axiiv=0 after CHK. receive_axiiv is high in the cycle following that edge, for exactly 1 cycle.
- r_opp_rst pulses in the same cycle as receive_axiiv, only if the rst bit is set. Other field outputs hold until the next commit.
- Rejected frames change no field output and produce no strobe.
- rx_err_count increments at most once per frame and saturates at 255.
- Timeout counter:
  - Clears on commit and counts otherwise.
  - link_up=0 when the count reaches TIMEOUT_CYCLES; the counter stays saturated there.
  - link_up=1 from the cycle after the next commit.
- Reset (asynchronous, active-low):
  - FSM to IDLE.
  - r_opp_x=INIT_X, r_opp_y=INIT_Y, r_opp_dir=INIT_DIR, r_opp_game=0.
  - r_opp_rst=0, receive_axiiv=0, link_up=0, rx_err_count=0, timeout counter=0.
  - Reset in mid-frame discards the partial frame. After release, the FSM resynchronises on the next axiiv low-to-high transition; bytes of the interrupted frame are dropped as a header error.
- Back-to-back frames need at least one axiiv=0 cycle between them.

Decomposition:
- Shared package game_pkg holds:
  - field widths (X_W=11, Y_W=11, DIR_W=9, GAME_W=3);
  - the payload bit-position constants;
  - the rx state enum.
- The same package is to be reused by the transmit-side packet builder.
- One sub-module, rx_link_timer, implements the timeout counter and link_up.

Test Plan:
- Send A5 25 81 90 B4 00 EA, then axiiv=0 -> one cycle later: receive_axiiv=1 for 1 cycle, x=300, y=100, dir=90, game=0, r_opp_rst=0; rx_err_count stays 0.
- Same frame with CHK=EB -> no strobe, fields unchanged, rx_err_count=1.
- Valid-checksum frame with dir=360 -> rejected, rx_err_count+1. Frame with dir=359 -> accepted.
- Truncated frame (axiiv falls after P2) -> error+1. 8-byte frame -> error+1, and the FSM stays in DROP until axiiv=0. A following good frame must be accepted.
- Frame with rst bit=1 and game=1 -> r_opp_rst pulses exactly with receive_axiiv; r_opp_game=1 holds afterwards.
- TIMEOUT_CYCLES=100 with no frames -> link_up=0. Good frame -> link_up=1 one cycle after commit. Assert rst_n=0 mid-payload -> all outputs reset immediately, and the next frame is parsed correctly.

Source files
------------

// File: rtl/game_pkg.sv
// Shared kart-link definitions: field widths, payload bit positions and rx parser states.
// Also used by the transmit-side packet builder so both ends agree on the layout.
package game_pkg;

  localparam int X_W    = 11;
  localparam int Y_W    = 11;
  localparam int DIR_W  = 9;
  localparam int GAME_W = 3;

  localparam int PL_W     = 40;
  localparam int PL_BYTES = 5;

  localparam int X_MSB    = 39;
  localparam int X_LSB    = 29;
  localparam int Y_MSB    = 28;
  localparam int Y_LSB    = 18;
  localparam int DIR_MSB  = 17;
  localparam int DIR_LSB  = 9;
  localparam int GAME_MSB = 8;
  localparam int GAME_LSB = 6;
  localparam int RST_BIT  = 5;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_PAYLOAD,
    RX_CHK,
    RX_WAIT_END,
    RX_DROP
  } rx_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/rx_link_timer.sv
// Link liveness: counts cycles since the last committed frame and drops link_up at the timeout.
module rx_link_timer #(
  parameter int TIMEOUT_CYCLES = 6_500_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic commit_i,
  output logic link_up_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] count_q, count_d;
  logic          link_up_q, link_up_d;

  // Counter parks at LIMIT so it never wraps back into the "alive" range.
  always_comb begin
    count_d   = count_q;
    link_up_d = link_up_q;
    if (commit_i) begin
      count_d   = '0;
      link_up_d = 1'b1;
    end else begin
      if (count_q != LIMIT) count_d = count_q + 1'b1;
      if (count_d == LIMIT) link_up_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= '0;
      link_up_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      link_up_q <= link_up_d;
    end
  end

  assign link_up_o = link_up_q;

endmodule

// File: rtl/opp_packet_rx.sv
// Opponent kart-state frame parser: validates header/length/checksum/direction,
// latches the fields on a good frame and strobes receive_axiiv for one cycle.
module opp_packet_rx
  import game_pkg::*;
#(
  parameter logic [7:0] HEADER         = 8'hA5,
  parameter int         DIR_MAX        = 359,
  parameter int         INIT_X         = 300,
  parameter int         INIT_Y         = 100,
  parameter int         INIT_DIR       = 90,
  parameter int         TIMEOUT_CYCLES = 6_500_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              axiiv,
  input  logic [7:0]        axiid,
  output logic [X_W-1:0]    r_opp_x,
  output logic [Y_W-1:0]    r_opp_y,
  output logic [DIR_W-1:0]  r_opp_dir,
  output logic [GAME_W-1:0] r_opp_game,
  output logic              r_opp_rst,
  output logic              receive_axiiv,
  output logic              link_up,
  output logic [7:0]        rx_err_count
);

  rx_state_e         state_q;
  logic [2:0]        cnt_q;
  logic [PL_W-1:0]   shift_q;
  logic [7:0]        sum_q;
  logic [7:0]        chk_q;
  logic [X_W-1:0]    x_q;
  logic [Y_W-1:0]    y_q;
  logic [DIR_W-1:0]  dir_q;
  logic [GAME_W-1:0] game_q;
  logic              opp_rst_q;
  logic              strobe_q;
  logic [7:0]        err_q;

  logic frame_ok_d;
  logic commit_d;

  assign frame_ok_d = (chk_q == sum_q) && (shift_q[DIR_MSB:DIR_LSB] <= DIR_W'(DIR_MAX));
  assign commit_d   = (state_q == RX_WAIT_END) && !axiiv && frame_ok_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RX_IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      sum_q     <= '0;
      chk_q     <= '0;
      x_q       <= X_W'(INIT_X);
      y_q       <= Y_W'(INIT_Y);
      dir_q     <= DIR_W'(INIT_DIR);
      game_q    <= '0;
      opp_rst_q <= 1'b0;
      strobe_q  <= 1'b0;
      err_q     <= '0;
    end else begin
      strobe_q  <= 1'b0;
      opp_rst_q <= 1'b0;
      case (state_q)
        RX_IDLE: begin
          if (axiiv) begin
            if (axiid == HEADER) begin
              state_q <= RX_PAYLOAD;
              cnt_q   <= '0;
              sum_q   <= '0;
            end else begin
              state_q <= RX_DROP;
              err_q   <= sat_inc8(err_q);
            end
          end
        end
        RX_PAYLOAD: begin
          if (axiiv) begin
            shift_q <= {shift_q[PL_W-9:0], axiid};
            sum_q   <= sum_q + axiid;
            cnt_q   <= cnt_q + 3'd1;
            if (cnt_q == 3'(PL_BYTES - 1)) state_q <= RX_CHK;
          end else begin
            state_q <= RX_IDLE;
            err_q   <= sat_inc8(err_q);
          end
        end
        RX_CHK: begin
          if (axiiv) begin
            chk_q   <= axiid;
            state_q <= RX_WAIT_END;
          end else begin
            state_q <= RX_IDLE;
            err_q   <= sat_inc8(err_q);
          end
        end
        RX_WAIT_END: begin
          if (axiiv) begin
            state_q <= RX_DROP;
            err_q   <= sat_inc8(err_q);
          end else begin
            state_q <= RX_IDLE;
            if (commit_d) begin
              x_q       <= shift_q[X_MSB:X_LSB];
              y_q       <= shift_q[Y_MSB:Y_LSB];
              dir_q     <= shift_q[DIR_MSB:DIR_LSB];
              game_q    <= shift_q[GAME_MSB:GAME_LSB];
              opp_rst_q <= shift_q[RST_BIT];
              strobe_q  <= 1'b1;
            end else begin
              err_q <= sat_inc8(err_q);
            end
          end
        end
        RX_DROP: begin
          if (!axiiv) state_q <= RX_IDLE;
        end
        default: state_q <= RX_IDLE;
      endcase
    end
  end

  rx_link_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_link_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .commit_i (commit_d),
    .link_up_o(link_up)
  );

  assign r_opp_x       = x_q;
  assign r_opp_y       = y_q;
  assign r_opp_dir     = dir_q;
  assign r_opp_game    = game_q;
  assign r_opp_rst     = opp_rst_q;
  assign receive_axiiv = strobe_q;
  assign rx_err_count  = err_q;

endmodule
